// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU control codes,
// R-type funct values, main-decoder alu_op classes, FSM state and the
// decoded-op payload passed from the funct decoder to the sequencer.
package alu_ctrl_pkg;

    localparam int unsigned ENC_W = 3;  // native width of the ALU codes
    localparam int unsigned CNT_W = 4;  // latency counter width

    // ALU control encodings (zero-extended to CTRL_W at the top)
    localparam logic [ENC_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ENC_W-1:0] ALU_OR  = 3'd1;
    localparam logic [ENC_W-1:0] ALU_SUB = 3'd2;
    localparam logic [ENC_W-1:0] ALU_SLT = 3'd3;
    localparam logic [ENC_W-1:0] ALU_AND = 3'd4;
    localparam logic [ENC_W-1:0] ALU_MUL = 3'd5;
    localparam logic [ENC_W-1:0] ALU_DIV = 3'd6;

    // R-type function field values
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_DIV = 6'h1A;

    // Main-decoder ALU op classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    // Decoded op: control code, multi-cycle flag, latency, illegal flag
    typedef struct packed {
        logic [ENC_W-1:0] ctrl;
        logic             is_multi;
        logic [CNT_W-1:0] lat;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational {alu_op, funct} decoder.
// Ports:
//   alu_op  in   2      main-decoder ALU op class
//   funct   in   6      R-type function field
//   dec     out  dec_t  control code, multi-cycle flag, latency, illegal
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_LAT   = 8,
    parameter int unsigned EN_MULDIV = 1
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Unknown functs fall back to ADD and raise illegal
    always_comb begin
        dec          = '0;
        dec.ctrl     = ALU_ADD;
        unique case (alu_op)
            ALUOP_ADD: dec.ctrl = ALU_ADD;
            ALUOP_SUB: dec.ctrl = ALU_SUB;
            ALUOP_OR:  dec.ctrl = ALU_OR;
            default: begin
                unique case (funct)
                    FUNCT_ADD: dec.ctrl = ALU_ADD;
                    FUNCT_SUB: dec.ctrl = ALU_SUB;
                    FUNCT_AND: dec.ctrl = ALU_AND;
                    FUNCT_OR:  dec.ctrl = ALU_OR;
                    FUNCT_SLT: dec.ctrl = ALU_SLT;
                    FUNCT_MUL: begin
                        if (EN_MULDIV != 0) begin
                            dec.ctrl     = ALU_MUL;
                            dec.is_multi = 1'b1;
                            dec.lat      = CNT_W'(MUL_LAT);
                        end else begin
                            dec.illegal  = 1'b1;
                        end
                    end
                    FUNCT_DIV: begin
                        if (EN_MULDIV != 0) begin
                            dec.ctrl     = ALU_DIV;
                            dec.is_multi = 1'b1;
                            dec.lat      = CNT_W'(DIV_LAT);
                        end else begin
                            dec.illegal  = 1'b1;
                        end
                    end
                    default:   dec.illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control sequencer. Decodes {alu_op, funct}
// into an ALU control word, holds it for the op's full latency and
// supports multi-cycle MUL/DIV.
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous abort of in-flight op
//   in_valid   in   1       upstream op valid
//   in_ready   out  1       block can accept an op this cycle (combinational)
//   alu_op     in   2       main-decoder ALU op class
//   funct      in   6       R-type function field
//   out_valid  out  1       alu_ctrl/illegal valid for execute stage
//   out_ready  in   1       execute stage consumes result
//   alu_ctrl   out  CTRL_W  ALU control word
//   busy       out  1       multi-cycle unit active
//   illegal    out  1       accepted op decoded as illegal
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned MUL_LAT   = 4,
    parameter int unsigned DIV_LAT   = 8,
    parameter int unsigned EN_MULDIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              busy,
    output logic              illegal
);

    // Elaboration-time parameter checks
    if (CTRL_W < ENC_W) begin : g_bad_ctrl_w
        $error("alu_ctrl_seq: CTRL_W must be >= 3");
    end
    if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_ctrl_seq: MUL_LAT must be in 2..15");
    end
    if (DIV_LAT < 2 || DIV_LAT > 15) begin : g_bad_div_lat
        $error("alu_ctrl_seq: DIV_LAT must be in 2..15");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                illegal_q, illegal_d;
    logic                multi_q, multi_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                in_ready_c;
    logic                accept_c;
    dec_t                dec;

    alu_funct_decode #(
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT),
        .EN_MULDIV (EN_MULDIV)
    ) u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .dec    (dec)
    );

    // Handshake: accept in IDLE, or in VALID when the result drains this cycle
    always_comb begin
        in_ready_c = ~flush & ((state_q == ST_IDLE) |
                               ((state_q == ST_VALID) & out_ready));
        accept_c   = in_valid & in_ready_c;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctrl_q      <= CTRL_W'(ALU_ADD);
            illegal_q   <= 1'b0;
            multi_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
            multi_q     <= multi_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state and latency counter; an accept is handled the same from IDLE or VALID
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept_c) begin
            if (dec.is_multi) begin
                // LAT-2 so that out_valid rises exactly LAT cycles after accept
                state_d = ST_BUSY;
                cnt_d   = dec.lat - CNT_W'(2);
            end else begin
                state_d = ST_VALID;
            end
        end else begin
            unique case (state_q)
                ST_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register inputs: control word captured at accept, flags from next state
    always_comb begin
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        multi_d   = multi_q;
        if (accept_c) begin
            ctrl_d    = CTRL_W'(dec.ctrl);
            illegal_d = dec.illegal;
            multi_d   = dec.is_multi;
        end
        out_valid_d = (state_d == ST_VALID);
        busy_d      = (state_d == ST_BUSY) | ((state_d == ST_VALID) & multi_d);
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign alu_ctrl  = ctrl_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;

endmodule
